switch_debouncer: RTL and testbench

Input-conditioning stage for the lab gate designs. It takes raw slide-switch/pushbutton levels from board pins, synchronizes each one to `clk`, and debounces it with a per-channel counter FSM. It then presents glitch-free levels (`sw_clean`) that drive the gate inputs directly (`sw_clean[0]` → `a`, `sw_clean[1]` → `b`). One-cycle edge pulses are also provided for downstream counters.

---
 rtl/lab_input_pkg.sv | 15 +
 rtl/debounce_channel.sv | 112 +++++++++++
 rtl/switch_debouncer.sv | 32 +++
 tb/tb_switch_debouncer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lab_input_pkg.sv
// Shared types and constants for the lab input-conditioning blocks.
package lab_input_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_PEND_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_PEND_LOW  = 2'd3
  } debounce_state_t;

  // 10 ms at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage : lab_input_pkg

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-FF synchronizer, qualify-counter FSM and
// registered clean level with one-cycle edge pulses.
module debounce_channel
  import lab_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  debounce_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            clean_q, clean_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // State, counter, synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_LOW;
      cnt_q   <= CNT_ZERO;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic; pulses only on the commit cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      S_LOW: begin
        if (sync2_q) begin
          state_d = S_PEND_HIGH;
          cnt_d   = CNT_ONE;
        end
      end

      S_PEND_HIGH: begin
        if (!sync2_q) begin
          state_d = S_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HIGH: begin
        if (!sync2_q) begin
          state_d = S_PEND_LOW;
          cnt_d   = CNT_ONE;
        end
      end

      S_PEND_LOW: begin
        if (sync2_q) begin
          state_d = S_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// Multi-channel switch/pushbutton conditioner: one independent debounce
// channel per raw input bit.
module switch_debouncer
  import lab_input_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .sw_raw   (sw_raw[g]),
      .sw_clean (sw_clean[g]),
      .sw_rise  (sw_rise[g]),
      .sw_fall  (sw_fall[g])
    );
  end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: a window-based reference model
// predicts every cycle's outputs, a monitor compares after each edge.
module tb_switch_debouncer;

  localparam int unsigned W = 2;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];

  // Reference model: raw delayed two edges, and a window of the last D
  // delayed samples; a level is accepted once D samples in a row oppose it.
  logic [W-1:0] m_d1, m_d2, m_clean;
  logic [D-1:0] m_win [W];
  int           m_fill[W];

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  always #5 clk = ~clk;

  // Apply inputs for the next rising edge and queue the predicted outputs.
  task automatic step(input logic [W-1:0] raw, input logic rst);
    exp_t e;
    logic smp;
    sw_raw = raw;
    reset  = rst;
    e      = '0;
    if (rst) begin
      m_d1    = '0;
      m_d2    = '0;
      m_clean = '0;
      for (int c = 0; c < W; c++) begin
        m_win[c]  = '0;
        m_fill[c] = 0;
      end
    end else begin
      for (int c = 0; c < W; c++) begin
        smp       = m_d2[c];
        m_win[c]  = {m_win[c][D-2:0], smp};
        if (m_fill[c] < int'(D)) m_fill[c]++;
        if (m_fill[c] >= int'(D) && m_win[c] == {D{~m_clean[c]}}) begin
          m_clean[c] = ~m_clean[c];
          if (m_clean[c]) e.rise[c] = 1'b1;
          else            e.fall[c] = 1'b1;
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
    e.clean = m_clean;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  // Monitor: after every rising edge, pop one prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (sw_clean !== e.clean) begin
          n_bad++;
          $display("FAIL sw_clean t=%0t got=%b want=%b", $time, sw_clean, e.clean);
        end
        n_cmp++;
        if (sw_rise !== e.rise) begin
          n_bad++;
          $display("FAIL sw_rise t=%0t got=%b want=%b", $time, sw_rise, e.rise);
        end
        n_cmp++;
        if (sw_fall !== e.fall) begin
          n_bad++;
          $display("FAIL sw_fall t=%0t got=%b want=%b", $time, sw_fall, e.fall);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] cur;
    int           budget;

    // Reset held 3 cycles with both switches up, then requalify.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
    hold(2'b11, 8);

    // Back to idle low.
    step(2'b00, 1'b1);
    hold(2'b00, 4);

    // Clean press on channel 0.
    hold(2'b01, 8);

    // Bounce on channel 1, then a genuine press.
    step(2'b11, 1'b0);
    step(2'b01, 1'b0);
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    step(2'b01, 1'b0);
    hold(2'b01, 6);
    hold(2'b11, 8);

    // Release channel 1 then channel 0.
    hold(2'b01, 8);
    hold(2'b00, 8);

    // Simultaneous press on both channels.
    hold(2'b11, 8);
    hold(2'b00, 8);

    // Reset while channel 0 is mid-qualification, raw kept high.
    hold(2'b01, 4);
    step(2'b01, 1'b1);
    hold(2'b01, 9);
    step(2'b00, 1'b1);
    hold(2'b00, 3);

    // Randomized toggling with occasional reset.
    cur = '0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
      step(cur, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end
    hold(cur, 8);

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_switch_debouncer
